// File: rtl/br_tag_allocator.sv
// Branch tag allocator: hands out branch tags, tracks which tags are younger than each branch,
// and emits the one-cycle brupdate resolve/mispredict masks consumed by the killable queues.
module br_tag_allocator #(
  parameter  int MAX_BR_COUNT = 16,
  localparam int TAG_W        = $clog2(MAX_BR_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_flush,
  input  logic                    io_alloc_valid,
  output logic                    io_alloc_ready,
  output logic [TAG_W-1:0]        io_alloc_tag,
  output logic [MAX_BR_COUNT-1:0] io_inflight_mask,
  input  logic                    io_res_valid,
  input  logic [TAG_W-1:0]        io_res_tag,
  input  logic                    io_res_mispredict,
  output logic [MAX_BR_COUNT-1:0] io_brupdate_b1_resolve_mask,
  output logic [MAX_BR_COUNT-1:0] io_brupdate_b1_mispredict_mask,
  output logic [TAG_W:0]          io_free_count
);

  function automatic logic [TAG_W:0] count_free(input logic [MAX_BR_COUNT-1:0] v);
    logic [TAG_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_BR_COUNT; i++) begin
      cnt = cnt + (TAG_W+1)'(!v[i]);
    end
    return cnt;
  endfunction

  logic [MAX_BR_COUNT-1:0] inflight_r;
  logic [MAX_BR_COUNT-1:0] younger_r   [MAX_BR_COUNT];
  logic [MAX_BR_COUNT-1:0] resolve_mask_r;
  logic [MAX_BR_COUNT-1:0] mispredict_mask_r;
  logic [TAG_W:0]          free_count_r;

  logic [MAX_BR_COUNT-1:0] alloc_onehot_s;
  logic [TAG_W-1:0]        alloc_tag_s;
  logic                    alloc_ready_s;
  logic                    alloc_fire_s;
  logic [MAX_BR_COUNT-1:0] res_onehot_s;
  logic [MAX_BR_COUNT-1:0] res_younger_s;
  logic                    res_hit_s;
  logic                    res_kill_s;
  logic [MAX_BR_COUNT-1:0] kill_s;
  logic [MAX_BR_COUNT-1:0] clear_s;
  logic [MAX_BR_COUNT-1:0] inflight_n_s;
  logic [MAX_BR_COUNT-1:0] younger_n_s [MAX_BR_COUNT];

  // Grant selection and resolve decode; adding one to inflight ripples into its lowest clear bit.
  always_comb begin
    alloc_onehot_s = ~inflight_r & (inflight_r + {{(MAX_BR_COUNT-1){1'b0}}, 1'b1});
    alloc_tag_s    = '0;
    res_younger_s  = '0;
    for (int i = 0; i < MAX_BR_COUNT; i++) begin
      alloc_tag_s     = alloc_tag_s | (alloc_onehot_s[i] ? TAG_W'(i) : '0);
      res_onehot_s[i] = (io_res_tag == TAG_W'(i));
      res_younger_s   = res_younger_s | (res_onehot_s[i] ? younger_r[i] : '0);
    end
    alloc_ready_s = !(&inflight_r) && !(io_res_valid && io_res_mispredict) && !io_flush;
    alloc_fire_s  = io_alloc_valid && alloc_ready_s;
    res_hit_s     = io_res_valid && |(res_onehot_s & inflight_r);
    res_kill_s    = res_hit_s && io_res_mispredict;
    kill_s        = res_onehot_s | res_younger_s;
    clear_s       = res_hit_s ? (io_res_mispredict ? kill_s : res_onehot_s) : '0;
  end

  // Next inflight set and age matrix; a new tag only becomes younger than branches that survive.
  always_comb begin
    inflight_n_s = (inflight_r & ~clear_s) | (alloc_fire_s ? alloc_onehot_s : '0);
    for (int s = 0; s < MAX_BR_COUNT; s++) begin
      younger_n_s[s] = (clear_s[s] || (alloc_fire_s && alloc_onehot_s[s])) ? '0 :
                       ((younger_r[s] & ~clear_s) |
                        ((alloc_fire_s && inflight_r[s]) ? alloc_onehot_s : '0));
    end
  end

  // State and brupdate registers; flush wipes everything and suppresses same-cycle resolves.
  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      inflight_r        <= '0;
      resolve_mask_r    <= '0;
      mispredict_mask_r <= '0;
      free_count_r      <= (TAG_W+1)'(MAX_BR_COUNT);
      for (int s = 0; s < MAX_BR_COUNT; s++) begin
        younger_r[s] <= '0;
      end
    end else begin
      inflight_r        <= inflight_n_s;
      resolve_mask_r    <= res_hit_s ? res_onehot_s : '0;
      mispredict_mask_r <= res_kill_s ? kill_s : '0;
      free_count_r      <= count_free(inflight_n_s);
      for (int s = 0; s < MAX_BR_COUNT; s++) begin
        younger_r[s] <= younger_n_s[s];
      end
    end
  end

  assign io_alloc_ready                 = alloc_ready_s;
  assign io_alloc_tag                   = alloc_tag_s;
  assign io_inflight_mask               = inflight_r;
  assign io_brupdate_b1_resolve_mask    = resolve_mask_r;
  assign io_brupdate_b1_mispredict_mask = mispredict_mask_r;
  assign io_free_count                  = free_count_r;

endmodule

// File: tb/tb_br_tag_allocator.sv
// Bench for br_tag_allocator with four tags: directed scenarios plus random traffic
// checked against an age-ordered reference model.
module tb_br_tag_allocator;
  logic       clock = 1'b0;
  logic       reset;
  logic       io_flush;
  logic       io_alloc_valid;
  logic       io_alloc_ready;
  logic [1:0] io_alloc_tag;
  logic [3:0] io_inflight_mask;
  logic       io_res_valid;
  logic [1:0] io_res_tag;
  logic       io_res_mispredict;
  logic [3:0] rmask;
  logic [3:0] mmask;
  logic [2:0] io_free_count;

  int tests = 0;
  int fails = 0;

  br_tag_allocator #(.MAX_BR_COUNT(4)) dut (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_alloc_valid(io_alloc_valid), .io_alloc_ready(io_alloc_ready), .io_alloc_tag(io_alloc_tag),
    .io_inflight_mask(io_inflight_mask), .io_res_valid(io_res_valid), .io_res_tag(io_res_tag),
    .io_res_mispredict(io_res_mispredict), .io_brupdate_b1_resolve_mask(rmask),
    .io_brupdate_b1_mispredict_mask(mmask), .io_free_count(io_free_count)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic f, input logic av, input logic rv, input logic [1:0] rt,
                       input logic rm);
    io_flush = f; io_alloc_valid = av; io_res_valid = rv; io_res_tag = rt; io_res_mispredict = rm;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    tests += 5;
    if (io_inflight_mask !== 4'b0000) begin fails++; $display("FAIL reset_inflight got %b want 0000", io_inflight_mask); end
    if (io_free_count !== 3'd4) begin fails++; $display("FAIL reset_free got %0d want 4", io_free_count); end
    if (rmask !== 4'b0000) begin fails++; $display("FAIL reset_rmask got %b want 0000", rmask); end
    if (mmask !== 4'b0000) begin fails++; $display("FAIL reset_mmask got %b want 0000", mmask); end
    if (io_alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", io_alloc_ready); end
  endtask

  task automatic test_alloc_and_resolve();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      tests += 2;
      if (io_alloc_ready !== 1'b1) begin fails++; $display("FAIL alloc_ready[%0d] got %b want 1", i, io_alloc_ready); end
      if (io_alloc_tag !== 2'(i)) begin fails++; $display("FAIL alloc_tag[%0d] got %0d want %0d", i, io_alloc_tag, i); end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    tests += 2;
    if (io_inflight_mask !== 4'b0111) begin fails++; $display("FAIL alloc3_inflight got %b want 0111", io_inflight_mask); end
    if (io_free_count !== 3'd1) begin fails++; $display("FAIL alloc3_free got %0d want 1", io_free_count); end
    drive(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    tests += 3;
    if (rmask !== 4'b0010) begin fails++; $display("FAIL res1_rmask got %b want 0010", rmask); end
    if (mmask !== 4'b0000) begin fails++; $display("FAIL res1_mmask got %b want 0000", mmask); end
    if (io_inflight_mask !== 4'b0101) begin fails++; $display("FAIL res1_inflight got %b want 0101", io_inflight_mask); end
    tick();
    tests += 2;
    if (rmask !== 4'b0000) begin fails++; $display("FAIL res1_rmask_pulse got %b want 0000", rmask); end
    if (mmask !== 4'b0000) begin fails++; $display("FAIL res1_mmask_pulse got %b want 0000", mmask); end
    // younger[0] should now hold only tag 2: mispredicting tag 0 kills {0,2}
    drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    tests += 2;
    if (mmask !== 4'b0101) begin fails++; $display("FAIL younger0_mmask got %b want 0101", mmask); end
    if (io_inflight_mask !== 4'b0000) begin fails++; $display("FAIL younger0_inflight got %b want 0000", io_inflight_mask); end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc_n(4);
    drive(1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
    tests += 1;
    if (io_alloc_ready !== 1'b0) begin fails++; $display("FAIL misp_ready got %b want 0", io_alloc_ready); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    tests += 4;
    if (mmask !== 4'b1110) begin fails++; $display("FAIL misp_mmask got %b want 1110", mmask); end
    if (rmask !== 4'b0010) begin fails++; $display("FAIL misp_rmask got %b want 0010", rmask); end
    if (io_inflight_mask !== 4'b0001) begin fails++; $display("FAIL misp_inflight got %b want 0001", io_inflight_mask); end
    if (io_free_count !== 3'd3) begin fails++; $display("FAIL misp_free got %0d want 3", io_free_count); end
  endtask

  task automatic test_full();
    do_reset();
    alloc_n(4);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    tests += 2;
    if (io_alloc_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", io_alloc_ready); end
    if (io_free_count !== 3'd0) begin fails++; $display("FAIL full_free got %0d want 0", io_free_count); end
    drive(1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    tests += 1;
    if (io_alloc_ready !== 1'b0) begin fails++; $display("FAIL full_res_ready got %b want 0", io_alloc_ready); end
    tick();
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    tests += 3;
    if (io_alloc_ready !== 1'b1) begin fails++; $display("FAIL freed_ready got %b want 1", io_alloc_ready); end
    if (io_alloc_tag !== 2'd2) begin fails++; $display("FAIL freed_tag got %0d want 2", io_alloc_tag); end
    if (io_inflight_mask !== 4'b1011) begin fails++; $display("FAIL freed_inflight got %b want 1011", io_inflight_mask); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    tests += 1;
    if (io_inflight_mask !== 4'b1111) begin fails++; $display("FAIL refill_inflight got %b want 1111", io_inflight_mask); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_n(1);
    drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    tests += 2;
    if (io_alloc_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", io_alloc_ready); end
    if (io_alloc_tag !== 2'd1) begin fails++; $display("FAIL b2b_tag got %0d want 1", io_alloc_tag); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    tests += 3;
    if (io_inflight_mask !== 4'b0010) begin fails++; $display("FAIL b2b_inflight got %b want 0010", io_inflight_mask); end
    if (rmask !== 4'b0001) begin fails++; $display("FAIL b2b_rmask got %b want 0001", rmask); end
    if (mmask !== 4'b0000) begin fails++; $display("FAIL b2b_mmask got %b want 0000", mmask); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(2);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
    tests += 1;
    if (io_alloc_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got %b want 0", io_alloc_ready); end
    tick();
    drive(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    tests += 4;
    if (io_inflight_mask !== 4'b0000) begin fails++; $display("FAIL flush_inflight got %b want 0000", io_inflight_mask); end
    if (rmask !== 4'b0000) begin fails++; $display("FAIL flush_rmask got %b want 0000", rmask); end
    if (mmask !== 4'b0000) begin fails++; $display("FAIL flush_mmask got %b want 0000", mmask); end
    if (io_free_count !== 3'd4) begin fails++; $display("FAIL flush_free got %0d want 4", io_free_count); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    tests += 2;
    if (rmask !== 4'b0000) begin fails++; $display("FAIL stale_rmask got %b want 0000", rmask); end
    if (mmask !== 4'b0000) begin fails++; $display("FAIL stale_mmask got %b want 0000", mmask); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_n(3);
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    tests += 3;
    if (io_inflight_mask !== 4'b0000) begin fails++; $display("FAIL midrst_inflight got %b want 0000", io_inflight_mask); end
    if (mmask !== 4'b0000) begin fails++; $display("FAIL midrst_mmask got %b want 0000", mmask); end
    if (io_free_count !== 3'd4) begin fails++; $display("FAIL midrst_free got %0d want 4", io_free_count); end
  endtask

  // Model: a tag is younger than t exactly when it is in flight and was granted later than t.
  task automatic test_random();
    bit         m_live [4];
    int         m_age  [4];
    int         age_ctr;
    int         nlive;
    int         lowest;
    logic       f, av, rv, rm, exp_ready;
    logic [1:0] rt;
    logic [3:0] exp_r, exp_m, exp_live;
    do_reset();
    age_ctr = 0;
    for (int k = 0; k < 4; k++) begin m_live[k] = 1'b0; m_age[k] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      f  = ($urandom_range(0, 29) == 0);
      av = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 4);
      rm = ($urandom_range(0, 3) == 0);
      rt = 2'($urandom_range(0, 3));
      drive(f, av, rv, rt, rm);
      nlive = 0;
      lowest = -1;
      for (int k = 3; k >= 0; k--) begin
        if (m_live[k]) nlive++;
        else lowest = k;
      end
      exp_ready = (nlive != 4) && !(rv && rm) && !f;
      tests += 1;
      if (io_alloc_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready[%0d] got %b want %b", cyc, io_alloc_ready, exp_ready); end
      if (exp_ready) begin
        tests += 1;
        if (io_alloc_tag !== 2'(lowest)) begin fails++; $display("FAIL rnd_tag[%0d] got %0d want %0d", cyc, io_alloc_tag, lowest); end
      end
      exp_r = 4'b0000;
      exp_m = 4'b0000;
      if (f) begin
        for (int k = 0; k < 4; k++) m_live[k] = 1'b0;
      end else begin
        if (rv && m_live[rt]) begin
          exp_r[rt] = 1'b1;
          if (rm) begin
            for (int k = 0; k < 4; k++)
              if (m_live[k] && (k == int'(rt) || m_age[k] > m_age[rt])) exp_m[k] = 1'b1;
            for (int k = 0; k < 4; k++) if (exp_m[k]) m_live[k] = 1'b0;
          end else begin
            m_live[rt] = 1'b0;
          end
        end
        if (av && exp_ready) begin
          m_live[lowest] = 1'b1;
          m_age[lowest] = age_ctr;
          age_ctr++;
        end
      end
      tick();
      exp_live = 4'b0000;
      nlive = 0;
      for (int k = 0; k < 4; k++) begin
        exp_live[k] = m_live[k];
        if (m_live[k]) nlive++;
      end
      tests += 4;
      if (io_inflight_mask !== exp_live) begin fails++; $display("FAIL rnd_inflight[%0d] got %b want %b", cyc, io_inflight_mask, exp_live); end
      if (io_free_count !== 3'(4 - nlive)) begin fails++; $display("FAIL rnd_free[%0d] got %0d want %0d", cyc, io_free_count, 4 - nlive); end
      if (rmask !== exp_r) begin fails++; $display("FAIL rnd_rmask[%0d] got %b want %b", cyc, rmask, exp_r); end
      if (mmask !== exp_m) begin fails++; $display("FAIL rnd_mmask[%0d] got %b want %b", cyc, mmask, exp_m); end
    end
  endtask

  initial begin
    reset = 1'b1;
    io_flush = 1'b0; io_alloc_valid = 1'b0; io_res_valid = 1'b0;
    io_res_tag = 2'd0; io_res_mispredict = 1'b0;
    @(negedge clock);
    test_reset();
    test_alloc_and_resolve();
    test_mispredict();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
